pkt_slot_cache: RTL and testbench

Parametrised successor to the fixed 134-bit packet cache. It stores incoming packets in a slot-organised RAM and returns a slot ID with a free-slot count once each packet is committed. Stored packets are replayed by ID on request. New versus the previous generation: configurable data width, slot count and slot depth; explicit ID strobe; oversize and no-slot drop with a drop counter; a read-busy indication. Sits between the GPP-side packet input and the gate/dispatch stage.

---
 rtl/pkt_slot_cache_if.sv | 38 +++
 rtl/pkt_slot_cache.sv | 229 ++++++++++++++++++++++
 tb/tb_pkt_slot_cache.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_slot_cache_if.sv
// pkt_slot_cache port bundle: packet input, commit/ID side, replay side.
// slave is the cache, master is whatever feeds and drains it.
interface pkt_slot_cache_if #(
  parameter int DATA_W  = 134,
  parameter int SLOT_AW = 6
);
  logic              in_data_wr;
  logic [DATA_W-1:0] in_data;
  logic              in_valid_wr;
  logic              in_valid;
  logic              out_id_wr;
  logic [SLOT_AW-1:0] out_id;
  logic [SLOT_AW:0]  out_free_cnt;
  logic              in_id_wr;
  logic [SLOT_AW-1:0] in_id;
  logic              out_rd_busy;
  logic              out_data_wr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid_wr;
  logic              out_valid;
  logic [15:0]       out_drop_cnt;

  modport slave (
    input  in_data_wr, in_data, in_valid_wr, in_valid,
    input  in_id_wr, in_id,
    output out_id_wr, out_id, out_free_cnt,
    output out_rd_busy, out_data_wr, out_data,
    output out_valid_wr, out_valid, out_drop_cnt
  );

  modport master (
    output in_data_wr, in_data, in_valid_wr, in_valid,
    output in_id_wr, in_id,
    input  out_id_wr, out_id, out_free_cnt,
    input  out_rd_busy, out_data_wr, out_data,
    input  out_valid_wr, out_valid, out_drop_cnt
  );
endinterface

// File: rtl/pkt_slot_cache.sv
// Slot-organised packet cache: stores packets per slot, commits an ID,
// and replays a committed slot by ID before returning it to the free pool.
module pkt_slot_cache #(
  parameter int DATA_W  = 134,
  parameter int SLOT_AW = 6,
  parameter int FLIT_AW = 4
) (
  input  logic clk,
  input  logic rst,
  pkt_slot_cache_if.slave io
);
  localparam int SLOT_NUM   = 2**SLOT_AW;
  localparam int SLOT_DEPTH = 2**FLIT_AW;
  localparam int AW = SLOT_AW + FLIT_AW;

  typedef logic [SLOT_AW-1:0] slot_t;
  typedef logic [FLIT_AW:0]   len_t;
  typedef logic [SLOT_AW:0]   cnt_t;
  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT, R_DONE} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [SLOT_NUM-1:0] free_q, free_d;
  logic [SLOT_NUM-1:0] cmt_q, cmt_d;
  len_t  len_q [SLOT_NUM];
  len_t  len_d [SLOT_NUM];
  cnt_t  free_cnt_q, free_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  slot_t cur_slot_q, cur_slot_d;
  len_t  widx_q, widx_d;
  logic  ovf_q, ovf_d;
  logic  id_wr_q, id_wr_d;
  slot_t id_q, id_d;
  slot_t rd_slot_q, rd_slot_d;
  len_t  rd_len_q, rd_len_d;
  len_t  ridx_q, ridx_d;
  logic  dwr_q, dwr_d;

  logic [DATA_W-1:0] mem [SLOT_NUM*SLOT_DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic  mem_we, rd_en;
  slot_t alloc_slot;
  logic  is_head, start, alloc, rel_w, rel_r;
  logic  drop, commit, cmt_clr;

  assign is_head = io.in_data_wr &&
                   (io.in_data[DATA_W-1:DATA_W-2] == 2'b01);

  always_comb begin
    alloc_slot = '0;
    for (int i = SLOT_NUM-1; i >= 0; i--)
      if (free_q[i]) alloc_slot = slot_t'(i);
  end

  always_comb begin
    w_state_d  = w_state_q;
    cur_slot_d = cur_slot_q;
    widx_d     = widx_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    start      = 1'b0;
    alloc      = 1'b0;
    rel_w      = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    unique case (w_state_q)
      W_IDLE: start = is_head;
      W_PKT: begin
        if (is_head && !io.in_valid_wr) begin
          rel_w = 1'b1;
          drop  = 1'b1;
          start = 1'b1;
        end else begin
          if (io.in_data_wr && !is_head) begin
            if (widx_q == len_t'(SLOT_DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = {cur_slot_q, widx_q[FLIT_AW-1:0]};
              widx_d    = widx_q + 1'b1;
            end
          end
          // a same-cycle tail is already folded into widx_d/ovf_d
          if (io.in_valid_wr) begin
            w_state_d = W_IDLE;
            if (io.in_valid && !ovf_d) begin
              commit = 1'b1;
            end else begin
              rel_w = 1'b1;
              drop  = 1'b1;
            end
          end
        end
      end
      W_DROP: begin
        if (io.in_valid_wr) begin
          drop      = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (start) begin
      if (free_cnt_q != '0) begin
        alloc      = 1'b1;
        cur_slot_d = alloc_slot;
        widx_d     = len_t'(1);
        ovf_d      = 1'b0;
        mem_we     = 1'b1;
        mem_waddr  = {alloc_slot, {FLIT_AW{1'b0}}};
        w_state_d  = W_PKT;
      end else begin
        w_state_d = W_DROP;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_slot_d = rd_slot_q;
    rd_len_d  = rd_len_q;
    ridx_d    = ridx_q;
    cmt_clr   = 1'b0;
    rel_r     = 1'b0;
    rd_en     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (io.in_id_wr && cmt_q[io.in_id]) begin
          cmt_clr   = 1'b1;
          rd_slot_d = io.in_id;
          rd_len_d  = len_q[io.in_id];
          ridx_d    = '0;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        rd_en  = 1'b1;
        ridx_d = ridx_q + 1'b1;
        if (ridx_d == rd_len_q) r_state_d = R_WAIT;
      end
      R_WAIT: r_state_d = R_DONE;
      R_DONE: begin
        rel_r     = 1'b1;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign mem_raddr = {rd_slot_q, ridx_q[FLIT_AW-1:0]};

  always_comb begin
    free_d = free_q;
    cmt_d  = cmt_q;
    len_d  = len_q;
    if (rel_w) free_d[cur_slot_q] = 1'b1;
    if (rel_r) free_d[rd_slot_q]  = 1'b1;
    if (alloc) free_d[alloc_slot] = 1'b0;
    if (commit) begin
      cmt_d[cur_slot_q] = 1'b1;
      len_d[cur_slot_q] = widx_d;
    end
    if (cmt_clr) cmt_d[io.in_id] = 1'b0;
    free_cnt_d = free_cnt_q + cnt_t'(rel_w) + cnt_t'(rel_r)
               - cnt_t'(alloc);
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    id_wr_d = commit;
    id_d    = commit ? cur_slot_q : id_q;
    dwr_d   = rd_en;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= io.in_data;
    if (rd_en)  rd_data_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      free_q     <= '1;
      cmt_q      <= '0;
      len_q      <= '{default: '0};
      free_cnt_q <= cnt_t'(SLOT_NUM);
      drop_cnt_q <= '0;
      cur_slot_q <= '0;
      widx_q     <= '0;
      ovf_q      <= 1'b0;
      id_wr_q    <= 1'b0;
      id_q       <= '0;
      rd_slot_q  <= '0;
      rd_len_q   <= '0;
      ridx_q     <= '0;
      dwr_q      <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      free_q     <= free_d;
      cmt_q      <= cmt_d;
      len_q      <= len_d;
      free_cnt_q <= free_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      cur_slot_q <= cur_slot_d;
      widx_q     <= widx_d;
      ovf_q      <= ovf_d;
      id_wr_q    <= id_wr_d;
      id_q       <= id_d;
      rd_slot_q  <= rd_slot_d;
      rd_len_q   <= rd_len_d;
      ridx_q     <= ridx_d;
      dwr_q      <= dwr_d;
    end
  end

  assign io.out_id_wr    = id_wr_q;
  assign io.out_id       = id_q;
  assign io.out_free_cnt = free_cnt_q;
  assign io.out_drop_cnt = drop_cnt_q;
  assign io.out_rd_busy  = (r_state_q != R_IDLE);
  assign io.out_data_wr  = dwr_q;
  assign io.out_data     = dwr_q ? rd_data_q : '0;
  assign io.out_valid_wr = (r_state_q == R_DONE);
  assign io.out_valid    = (r_state_q == R_DONE);
endmodule

// File: tb/tb_pkt_slot_cache.sv
// Randomised bench for pkt_slot_cache against a slot-level packet model.
// Model tracks slot ownership, stored packets and drop count directly.
module tb_pkt_slot_cache;
  localparam int DW  = 134;
  localparam int SAW = 6;
  localparam int FAW = 4;
  localparam int NS  = 64;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_slot_cache_if #(.DATA_W(DW), .SLOT_AW(SAW)) io ();

  pkt_slot_cache #(
    .DATA_W(DW), .SLOT_AW(SAW), .FLIT_AW(FAW)
  ) dut (
    .clk(clk), .rst(rst), .io(io.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // slot state: 0 free, 1 committed, 2 owned by writer/reader
  int st [NS];
  logic [DW-1:0] mdat [NS][DEP];
  int mlen [NS];
  int mdrop = 0;
  bit conc = 1'b0;

  task automatic chk(string tag, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nfree();
    int c = 0;
    for (int i = 0; i < NS; i++) if (st[i] == 0) c++;
    return c;
  endfunction

  function automatic int lowest();
    for (int i = 0; i < NS; i++) if (st[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] mk_flit(int i, int n);
    logic [DW-1:0] f = '0;
    for (int k = 0; k < 5; k++) f = {f[DW-33:0], 32'($urandom)};
    f[DW-1:DW-2] = (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b11;
    return f;
  endfunction

  task automatic idle_in();
    io.in_data_wr  = 1'b0;
    io.in_data     = '0;
    io.in_valid_wr = 1'b0;
    io.in_valid    = 1'b0;
    io.in_id_wr    = 1'b0;
    io.in_id       = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_id_wr", io.out_id_wr, 0);
    chk("rst_id", io.out_id, 0);
    chk("rst_free", io.out_free_cnt, NS);
    chk("rst_drop", io.out_drop_cnt, 0);
    chk("rst_busy", io.out_rd_busy, 0);
    chk("rst_dwr", io.out_data_wr, 0);
    chk("rst_data", io.out_data, 0);
    chk("rst_vwr", io.out_valid_wr, 0);
    chk("rst_valid", io.out_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) st[i] = 0;
    mdrop = 0;
  endtask

  task automatic send_pkt(int n, bit keep, bit same, int gap);
    logic [DW-1:0] fl [$];
    int id = -1;
    bit avail = 1'b0;
    bit commit;
    for (int i = 0; i < n; i++) fl.push_back(mk_flit(i, n));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1 && !conc)
        chk("alloc_free", io.out_free_cnt, nfree());
      io.in_data_wr  = 1'b1;
      io.in_data     = fl[i];
      io.in_valid_wr = same && (i == n-1);
      io.in_valid    = keep;
      if (i == 0) begin
        #1;
        id = lowest();
        avail = (id >= 0);
        if (avail) st[id] = 2;
      end
    end
    if (!same) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        io.in_data_wr = 1'b0;
      end
      @(negedge clk);
      io.in_data_wr  = 1'b0;
      io.in_valid_wr = 1'b1;
      io.in_valid    = keep;
    end
    @(negedge clk);
    io.in_data_wr  = 1'b0;
    io.in_valid_wr = 1'b0;
    commit = avail && keep && (n <= DEP);
    chk("id_wr", io.out_id_wr, commit);
    if (commit) begin
      chk("id", io.out_id, id);
      st[id] = 1;
      mlen[id] = n;
      for (int k = 0; k < n; k++) mdat[id][k] = fl[k];
    end else begin
      if (avail) st[id] = 0;
      if (mdrop < 65535) mdrop++;
    end
    chk("drop_cnt", io.out_drop_cnt, mdrop);
    if (!conc) chk("free_cnt", io.out_free_cnt, nfree());
  endtask

  task automatic read_slot(int id, int intr);
    bit ok = (st[id] == 1);
    int len = mlen[id];
    @(negedge clk);
    io.in_id_wr = 1'b1;
    io.in_id    = SAW'(id);
    if (ok) st[id] = 2;
    @(negedge clk);
    chk("rd_busy", io.out_rd_busy, ok);
    if (intr >= 0) io.in_id = SAW'(intr);
    else io.in_id_wr = 1'b0;
    if (!ok) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        io.in_id_wr = 1'b0;
        chk("rd_ign_dwr", io.out_data_wr, 0);
        chk("rd_ign_busy", io.out_rd_busy, 0);
      end
      if (!conc) chk("rd_ign_free", io.out_free_cnt, nfree());
      return;
    end
    @(negedge clk);
    io.in_id_wr = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk("rd_dwr", io.out_data_wr, 1);
      chk("rd_data", io.out_data, mdat[id][k]);
      @(negedge clk);
    end
    chk("rd_vwr", io.out_valid_wr, 1);
    chk("rd_valid", io.out_valid, 1);
    chk("rd_end_busy", io.out_rd_busy, 1);
    chk("rd_end_dwr", io.out_data_wr, 0);
    @(negedge clk);
    st[id] = 0;
    chk("rd_idle", io.out_rd_busy, 0);
    chk("rd_idle_vwr", io.out_valid_wr, 0);
    if (!conc) chk("rd_free", io.out_free_cnt, nfree());
  endtask

  function automatic int pick_cmt();
    int s = $urandom_range(0, NS-1);
    for (int i = 0; i < NS; i++)
      if (st[(s + i) % NS] == 1) return (s + i) % NS;
    return -1;
  endfunction

  initial begin
    int c, n, dly;
    idle_in();
    do_reset();

    send_pkt(3, 1'b1, 1'b0, 0);
    read_slot(0, -1);
    send_pkt(17, 1'b1, 1'b0, 1);
    send_pkt(2, 1'b0, 1'b1, 0);
    send_pkt(16, 1'b1, 1'b1, 0);
    read_slot(0, -1);

    for (int i = 0; i < NS; i++)
      send_pkt($urandom_range(2, 5), 1'b1, 1'($urandom), 0);
    send_pkt(3, 1'b1, 1'b0, 0);
    read_slot(5, -1);
    send_pkt(2, 1'b1, 1'b1, 0);
    read_slot(7, -1);
    read_slot(7, -1);
    read_slot(8, 9);
    read_slot(9, -1);

    for (int it = 0; it < 60; it++) begin
      c = $urandom_range(0, 9);
      if (c < 4) begin
        n = ($urandom_range(0, 4) == 0) ? $urandom_range(17, 20)
                                        : $urandom_range(2, 16);
        send_pkt(n, $urandom_range(0, 4) != 0, 1'($urandom),
                 $urandom_range(0, 2));
      end else if (c < 8) begin
        n = pick_cmt();
        if (n < 0 || $urandom_range(0, 3) == 0)
          n = $urandom_range(0, NS-1);
        read_slot(n, -1);
      end else begin
        n = pick_cmt();
        if (n >= 0) begin
          dly = $urandom_range(0, 20);
          conc = 1'b1;
          fork
            read_slot(n, -1);
            begin
              repeat (dly) @(negedge clk);
              send_pkt($urandom_range(2, 8), 1'b1, 1'($urandom), 0);
            end
          join
          conc = 1'b0;
          @(negedge clk);
          chk("conc_free", io.out_free_cnt, nfree());
        end
      end
    end

    @(negedge clk);
    io.in_data_wr = 1'b1;
    io.in_data    = mk_flit(0, 3);
    @(negedge clk);
    io.in_data    = mk_flit(1, 3);
    do_reset();
    send_pkt(3, 1'b1, 1'b0, 0);

    @(negedge clk);
    io.in_id_wr = 1'b1;
    io.in_id    = '0;
    @(negedge clk);
    io.in_id_wr = 1'b0;
    @(negedge clk);
    do_reset();
    send_pkt(4, 1'b1, 1'b1, 0);
    read_slot(0, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
